// File: rtl/oam_dma_ctrl.sv
// Primary OAM write-port sequencer: CPU $2003/$2004 register writes and $4014 sprite DMA.
// DMA halts the CPU, reads one 256-byte page over the CPU bus and streams it into OAM.
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cycle,
  input  logic        dma_start,
  input  logic [7:0]  dma_page,
  input  logic        oamaddr_wr,
  input  logic [7:0]  oamaddr_data,
  input  logic        oamdata_wr,
  input  logic [7:0]  oamdata_in,
  input  logic        rendering,
  input  logic [7:0]  bus_data_in,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        cpu_halt,
  output logic        dma_busy,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  logic [2:0] state, state_next;
  logic [7:0] oamaddr, oamaddr_next;
  logic [7:0] page, page_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] latch, latch_next;
  logic       parity;
  logic       oam_we_next;
  logic [7:0] oam_addr_next, oam_wdata_next;

  // Next-state and write-port arbitration
  always_comb begin
    state_next     = state;
    oamaddr_next   = oamaddr;
    page_next      = page;
    cnt_next       = cnt;
    latch_next     = latch;
    oam_we_next    = 1'b0;
    oam_addr_next  = oam_addr;
    oam_wdata_next = oam_wdata;
    case (state)
      ST_IDLE: begin
        if (dma_start) begin
          page_next  = dma_page;
          cnt_next   = 8'd0;
          state_next = ST_HALT;
        end else if (oamaddr_wr) begin
          oamaddr_next = oamaddr_data;
        end else if (oamdata_wr && !rendering) begin
          oam_we_next    = 1'b1;
          oam_addr_next  = oamaddr;
          oam_wdata_next = oamdata_in;
          oamaddr_next   = oamaddr + 8'd1;
        end
      end
      ST_HALT: begin
        if (cpu_cycle) state_next = parity ? ST_ALIGN : ST_READ;
      end
      ST_ALIGN: begin
        if (cpu_cycle) state_next = ST_READ;
      end
      ST_READ: begin
        if (cpu_cycle) begin
          latch_next = bus_data_in;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (cpu_cycle) begin
          oam_we_next    = 1'b1;
          oam_addr_next  = oamaddr;
          oam_wdata_next = latch;
          oamaddr_next   = oamaddr + 8'd1;
          cnt_next       = cnt + 8'd1;
          state_next     = (cnt == 8'hFF) ? ST_IDLE : ST_READ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; bus/halt outputs track the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      oamaddr   <= 8'd0;
      page      <= 8'd0;
      cnt       <= 8'd0;
      latch     <= 8'd0;
      parity    <= 1'b0;
      oam_we    <= 1'b0;
      oam_addr  <= 8'd0;
      oam_wdata <= 8'd0;
      bus_rd    <= 1'b0;
      bus_addr  <= 16'd0;
      cpu_halt  <= 1'b0;
      dma_busy  <= 1'b0;
    end else begin
      state     <= state_next;
      oamaddr   <= oamaddr_next;
      page      <= page_next;
      cnt       <= cnt_next;
      latch     <= latch_next;
      if (cpu_cycle) parity <= ~parity;
      oam_we    <= oam_we_next;
      oam_addr  <= oam_addr_next;
      oam_wdata <= oam_wdata_next;
      bus_rd    <= (state_next == ST_READ);
      bus_addr  <= (state_next == ST_READ) ? {page_next, cnt_next} : 16'd0;
      cpu_halt  <= (state_next != ST_IDLE);
      dma_busy  <= (state_next != ST_IDLE);
    end
  end

endmodule
